seg7_stat_display: RTL and testbench
====================================

# seg7_stat_display

Eight-digit, time-multiplexed seven-segment driver sitting directly downstream of the CPU core. It consumes the CPU's syscall output register and the four statistics counters: total cycles, conditional branches, taken branches and unconditional jumps. It selects one of them with the board switches, freezes it into a frame snapshot and scans it out as 8 hex digits on the board's common-anode display.

## Interface
- REFRESH_DIV, default 100000: clk cycles each digit is lit; must be ≥ 2.
- BLANK_LZ, default 0: 1 enables leading-zero blanking.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sel  in  3  source select: 0 syscall_out, 1 t_all, 2 t_branch, 3 t_suc, 4 t_jump, 5–7 blank.
- syscall_out  in  32  value of the last syscall print.
- t_all  in  32  total cycle count.
- t_branch  in  32  conditional branch count.
- t_suc  in  32  taken conditional branch count.
- t_jump  in  32  unconditional jump count.
- SEG  out  8  segment lines, active-low: SEG[0]=a … SEG[6]=g, SEG[7]=dp.
- AN  out  8  digit anodes, active-low; AN[0] is the rightmost digit.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (pcnt == REFRESH_DIV-1).
- Digit index `idx` (3 bits) advances on `tick` and wraps 7→0.
- Snapshot register `snap[31:0]` and `snap_blank` hold the selected source value and the blank flag (sel ≥ 5).
- `snap` loads when any of these occur:
  - `tick` with idx==7, i.e. a frame boundary;
  - sel ≠ registered `sel_q` (a sel change);
  - `load_pend` is set; `load_pend` is set by rst and cleared by the first load.
- Between loads, `snap` is stable regardless of input changes, so all 8 digits of a frame show one coherent value.
- Digit value for the current idx: nibble = snap[4·idx+3 : 4·idx].
- Hex-to-segment encoding, active-low, dp always off (SEG[7]=1):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8;
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- AN = ~(1<<idx), except the digit is suppressed (AN=FF, SEG=FF) when either:
  - snap_blank is set; or
  - BLANK_LZ=1, idx > 0, and every nibble at position ≥ idx is zero.
- Digit 0 is never suppressed by leading-zero blanking, so a value of 0 shows a single "0".

## Timing
- During rst and in the cycle rst is sampled:
  - pcnt=0, idx=0, snap=0, snap_blank=1, sel_q=0, load_pend=1;
  - SEG=8'hFF, AN=8'hFF.
- First cycle after rst deasserts: snap/snap_blank load from the current sel and source, and load_pend clears.
- SEG and AN are registered, with one-cycle latency from idx/snap.
- Example: AN=FE first appears two cycles after rst deasserts and holds for REFRESH_DIV cycles.
- Each digit stays lit for exactly REFRESH_DIV cycles; a full frame is 8·REFRESH_DIV cycles.
- A sel change mid-frame reloads snap in the next cycle. idx and pcnt are not disturbed by the sel change; the new value appears from the current digit onward.
- If a frame-boundary tick and a sel change coincide: a single load occurs, using the new sel.
- Source inputs changing in the same cycle as a load: the value sampled that cycle is taken.
- rst mid-scan: all state returns to reset values in the next cycle, and the display blanks for that cycle.

## Structure
- Package seg7_pkg holds:
  - the select constants SEL_SYSCALL=0, SEL_ALL=1, SEL_BRANCH=2, SEL_SUC=3, SEL_JUMP=4;
  - the 16-entry segment pattern constants and SEG_BLANK=8'hFF.
- Sub-module hex_to_seg7 (4-bit in, 8-bit active-low out) is purely combinational and is instantiated once.
- Leading-zero mask: an 8-bit "nibble ≥ i nonzero" vector derived from snap. It is computed combinationally at load time and registered with snap.

## Test plan
- Reset scan: REFRESH_DIV=4, sel=1, t_all=32'h0000_00A5.
  - After rst, AN steps FE,FD,FB,…,7F, 4 cycles each.
  - SEG=92 on AN=FE, SEG=88 on AN=FD, SEG=C0 on the other six digits.
- Frame coherence: sel=0, syscall_out changes 12345678→9ABCDEF0 mid-frame.
  - Remaining digits of the current frame still show 12345678.
  - The next frame shows 9ABCDEF0.
- Sel change mid-frame: at idx=3, sel 1→4 with t_jump=32'hFFFF_FFFF.
  - From the next cycle, digits show SEG=8E.
  - idx continues to 4 without restarting.
- Blank select: sel=6 → AN=FF and SEG=FF for a full frame.
- Leading-zero blanking: BLANK_LZ=1, value 32'h0000_0300.
  - Digits 0–2 are lit, showing C0,C0,B0.
  - Digits 3–7 show AN=FF.
  - Value 0 lights only digit 0 with C0.
- Reset mid-operation: assert rst at idx=5 for one cycle.
  - Next cycle: SEG=FF, AN=FF.
  - Scan then restarts at digit 0 with a freshly loaded snapshot.

Source files
------------

// File: rtl/seg7_stat_display_pkg.sv
// Shared constants for the eight-digit statistics display: source selects
// and active-low seven-segment patterns.
package seg7_pkg;

  typedef enum logic [2:0] {
    SEL_SYSCALL = 3'd0,
    SEL_ALL     = 3'd1,
    SEL_BRANCH  = 3'd2,
    SEL_SUC     = 3'd3,
    SEL_JUMP    = 3'd4
  } sel_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the active-low pattern for hex digit n; dp (bit 7) stays off.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_stat_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg7_stat_display.sv
// Eight-digit multiplexed hex display of the CPU syscall register or one of
// the statistics counters, frozen per frame so every digit shows one value.
module seg7_stat_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic [31:0] syscall_out,
  input  logic [31:0] t_all,
  input  logic [31:0] t_branch,
  input  logic [31:0] t_suc,
  input  logic [31:0] t_jump,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned     PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap;
  logic          r_snap_blank;
  logic [7:0]    r_nz;
  logic [2:0]    r_sel_q;
  logic          r_load_pend;

  logic          w_tick;
  logic          w_load;
  logic [31:0]   w_src;
  logic          w_src_blank;
  logic [7:0]    w_nz;
  logic [3:0]    w_nib;
  logic [7:0]    w_seg;
  logic          w_suppress;

  assign w_tick = (r_pcnt == PMAX);
  assign w_load = (w_tick && (r_idx == 3'd7)) || (sel != r_sel_q) || r_load_pend;

  always_comb begin
    w_src       = '0;
    w_src_blank = 1'b0;
    case (sel)
      SEL_SYSCALL: w_src = syscall_out;
      SEL_ALL:     w_src = t_all;
      SEL_BRANCH:  w_src = t_branch;
      SEL_SUC:     w_src = t_suc;
      SEL_JUMP:    w_src = t_jump;
      default:     w_src_blank = 1'b1;
    endcase
  end

  // Bit i: some nibble at position >= i is nonzero.
  always_comb begin
    w_nz = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_nz[i] = |(w_src >> (4 * i));
    end
  end

  // The prescaler idles during the post-reset load cycle so the first digit,
  // like every other, is shown for the full REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_snap       <= '0;
      r_snap_blank <= 1'b1;
      r_nz         <= '0;
      r_sel_q      <= '0;
      r_load_pend  <= 1'b1;
    end else begin
      r_sel_q <= sel;
      if (!r_load_pend) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
        if (w_tick) r_idx <= r_idx + 3'd1;
      end
      if (w_load) begin
        r_snap       <= w_src;
        r_snap_blank <= w_src_blank;
        r_nz         <= w_nz;
        r_load_pend  <= 1'b0;
      end
    end
  end

  assign w_nib      = r_snap[{r_idx, 2'b00} +: 4];
  assign w_suppress = r_snap_blank || (BLANK_LZ && (r_idx != 3'd0) && !r_nz[r_idx]);

  hex_to_seg7 u_hex (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || w_suppress) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
    end else begin
      SEG <= w_seg;
      AN  <= ~(8'd1 << r_idx);
    end
  end

endmodule

// File: tb/tb_seg7_stat_display.sv
// Bench for seg7_stat_display: directed scenarios plus random traffic, both
// checked against an arithmetic model of frame timing and digit decoding.
module tb_seg7_stat_display;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = 3'd1;
  logic [31:0] syscall_out = '0;
  logic [31:0] t_all = 32'h0000_00A5;
  logic [31:0] t_branch = '0;
  logic [31:0] t_suc = '0;
  logic [31:0] t_jump = '0;
  logic [7:0]  seg0, an0, seg1, an1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  seg7_stat_display #(.REFRESH_DIV(N), .BLANK_LZ(1'b0)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .syscall_out(syscall_out), .t_all(t_all),
    .t_branch(t_branch), .t_suc(t_suc), .t_jump(t_jump), .SEG(seg0), .AN(an0)
  );

  seg7_stat_display #(.REFRESH_DIV(N), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .rst(rst), .sel(sel), .syscall_out(syscall_out), .t_all(t_all),
    .t_branch(t_branch), .t_suc(t_suc), .t_jump(t_jump), .SEG(seg1), .AN(an1)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: clock edges since reset released, and the frozen frame value.
  int unsigned k = 0;
  logic [31:0] m_snap = '0;
  logic        m_blank = 1'b1;
  logic [2:0]  m_sel_q = '0;

  function automatic int unsigned idx_of(input int unsigned kk);
    return (kk == 0) ? 0 : ((kk - 1) / N) % 8;
  endfunction

  function automatic logic [31:0] src_val();
    case (sel)
      3'd0:    return syscall_out;
      3'd1:    return t_all;
      3'd2:    return t_branch;
      3'd3:    return t_suc;
      3'd4:    return t_jump;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] exp_out(input logic [31:0] v, input logic blank,
                                          input int unsigned d, input bit lz);
    logic [31:0] hi;
    logic [7:0]  an;
    hi = v >> (4 * d);
    an = 8'h01 << d;
    if (blank || (lz && d > 0 && hi == 32'h0)) return 16'hFFFF;
    return {seg_ref[hi[3:0]], ~an};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s got SEG/AN=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input string tag);
    logic [15:0] e0, e1;
    e0 = exp_out(m_snap, m_blank, idx_of(k), 1'b0);
    e1 = exp_out(m_snap, m_blank, idx_of(k), 1'b1);
    if (k == 0 || (k % (8 * N)) == 0 || sel != m_sel_q) begin
      m_snap  = src_val();
      m_blank = (sel >= 3'd5);
    end
    m_sel_q = sel;
    @(posedge clk);
    #1;
    k++;
    check({tag, "/lz0"}, {seg0, an0}, e0);
    check({tag, "/lz1"}, {seg1, an1}, e1);
  endtask

  task automatic run(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_until_idx(input int unsigned d, input string tag);
    for (int unsigned i = 0; i < 8 * N + 1 && idx_of(k) != d; i++) step(tag);
  endtask

  task automatic do_reset(input int unsigned cycles, input string tag);
    rst = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/rst0"}, {seg0, an0}, 16'hFFFF);
      check({tag, "/rst1"}, {seg1, an1}, 16'hFFFF);
    end
    k = 0; m_snap = '0; m_blank = 1'b1; m_sel_q = '0;
    rst = 1'b0;
  endtask

  initial begin
    // Reset scan of 0x000000A5 on sel=1
    do_reset(3, "reset");
    run(2, "scan");
    check("first_digit", {seg0, an0}, 16'h92FE);
    run(N, "scan");
    check("second_digit", {seg0, an0}, 16'h88FD);
    run(8 * N, "scan");

    // Frame coherence on syscall_out
    syscall_out = 32'h1234_5678;
    sel = 3'd0;
    run(8 * N, "coh_load");
    run_until_idx(3, "coh_wait");
    syscall_out = 32'h9ABC_DEF0;
    run(16 * N, "coherence");

    // Sel change mid-frame to an all-F counter
    sel = 3'd1;
    t_all = 32'h0000_0001;
    run(8 * N, "sel_prep");
    run_until_idx(3, "sel_wait");
    t_jump = 32'hFFFF_FFFF;
    sel = 3'd4;
    run(2, "sel_chg");
    check("sel_chg_F", {seg0, an0}, 16'h8EF7);
    run(2 * N, "sel_after");

    // Blank select
    sel = 3'd6;
    run(9 * N, "blank");

    // Leading-zero blanking
    syscall_out = 32'h0000_0300;
    sel = 3'd0;
    run(10 * N, "lz300");
    syscall_out = 32'h0;
    run(9 * N, "lz0");

    // Reset mid-scan
    syscall_out = 32'hCAFE_F00D;
    run(8 * N, "pre_rst");
    run_until_idx(5, "rst_wait");
    do_reset(1, "mid_rst");
    run(2, "post_rst");
    check("post_rst_d0", {seg0, an0}, 16'hA1FE);
    run(8 * N, "post_rst");

    // Random traffic
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: syscall_out = $urandom >> $urandom_range(0, 31);
          1: t_all       = $urandom >> $urandom_range(0, 31);
          2: t_branch    = $urandom >> $urandom_range(0, 31);
          3: t_suc       = $urandom >> $urandom_range(0, 31);
          default: t_jump = $urandom >> $urandom_range(0, 31);
        endcase
      end
      if ($urandom_range(0, 39) == 0) sel = 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
